// File: rtl/alu_pkg.sv
// Shared ALU interface constants: control codes, R-type opcodes, ALUOp codes,
// latency classes and the issue-controller state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_MUL = 4'b0111;
  localparam logic [3:0] ALU_CTRL_DIV = 4'b0011;
  localparam logic [3:0] ALU_CTRL_NOP = 4'b1111;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_SDIV = 11'b10011010110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ILL   = 2'b11;

  typedef enum logic [1:0] {
    LAT_ONE,
    LAT_MUL,
    LAT_DIV
  } lat_sel_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUOp plus R-type opcode into ALU control code,
// latency class and an illegal flag.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0]  aluop,
  input  logic [10:0] opcode,
  output logic [3:0]  ctrl,
  output lat_sel_t    lat_sel,
  output logic        illegal
);

  always_comb begin
    ctrl    = ALU_CTRL_NOP;
    lat_sel = LAT_ONE;
    illegal = 1'b0;
    case (aluop)
      ALUOP_ADD: ctrl = ALU_CTRL_ADD;
      ALUOP_CMP: ctrl = ALU_CTRL_SUB;
      ALUOP_RTYPE: begin
        case (opcode)
          OPC_ADD: ctrl = ALU_CTRL_ADD;
          OPC_SUB: ctrl = ALU_CTRL_SUB;
          OPC_AND: ctrl = ALU_CTRL_AND;
          OPC_ORR: ctrl = ALU_CTRL_OR;
          OPC_MUL: begin
            ctrl    = ALU_CTRL_MUL;
            lat_sel = LAT_MUL;
          end
          OPC_SDIV: begin
            ctrl    = ALU_CTRL_DIV;
            lat_sel = LAT_DIV;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the 64-bit ALU interface: accepts one request, drives the
// ALU for the operation's latency, then returns the captured result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [10:0]      req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_ovf,
  output logic             rsp_illegal
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load;
  logic [3:0]       dec_ctrl;
  lat_sel_t         dec_lat;
  logic             dec_illegal;
  logic             accept;

  alu_ctrl_decode u_decode (
    .aluop   (req_aluop),
    .opcode  (req_opcode),
    .ctrl    (dec_ctrl),
    .lat_sel (dec_lat),
    .illegal (dec_illegal)
  );

  assign accept = req_valid && req_ready;

  // Counter holds LAT-1 so the capture edge lands exactly LAT edges after accept.
  always_comb begin
    cnt_load = '0;
    case (dec_lat)
      LAT_MUL: cnt_load = CNT_W'(MUL_LAT - 1);
      LAT_DIV: cnt_load = CNT_W'(DIV_LAT - 1);
      default: cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = dec_illegal ? RESP : EXEC;
      EXEC: if (cnt == '0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_ctrl    <= ALU_CTRL_NOP;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_ovf     <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (dec_illegal) begin
              alu_ctrl    <= ALU_CTRL_NOP;
              rsp_result  <= '0;
              rsp_zero    <= 1'b0;
              rsp_ovf     <= 1'b0;
              rsp_illegal <= 1'b1;
            end else begin
              alu_in1  <= req_a;
              alu_in2  <= req_b;
              alu_ctrl <= dec_ctrl;
              cnt      <= cnt_load;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_result  <= alu_result;
            rsp_zero    <= alu_zero;
            rsp_ovf     <= alu_ovf;
            rsp_illegal <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: if (rsp_ready) alu_ctrl <= ALU_CTRL_NOP;
        default: ;
      endcase
    end
  end

endmodule
